// File: rtl/tl_pkg.sv
// Shared TileLink-UH constants, tracker entry layout and beat-count helper.
package tl_pkg;
  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int TL_SIZE_BITS = 4;

  typedef struct packed {
    logic                    valid;
    logic [2:0]              expect_opcode;
    logic [TL_SIZE_BITS-1:0] size;
  } tl_entry_t;

  typedef enum logic {A_IDLE, A_BURST} a_state_e;
  typedef enum logic {D_IDLE, D_BURST} d_state_e;

  function automatic int unsigned beats(input int unsigned size, input int unsigned beat_lg);
    return (size <= beat_lg) ? 32'd1 : (32'd1 << (size - beat_lg));
  endfunction
endpackage

// File: rtl/tl_beat_counter.sv
// Remaining-beat counter for one channel burst: load, decrement, flag final beat.
module tl_beat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last = (cnt == W'(1));
endmodule

// File: rtl/tl_source_tracker.sv
// Passive per-source in-flight tracker for a TileLink-UH A/D link with
// burst beat counting and registered single-cycle protocol error pulses.
module tl_source_tracker
  import tl_pkg::*;
#(
  parameter int SOURCE_BITS = 2,
  parameter int SIZE_BITS   = 4,
  parameter int MAX_SIZE    = 6,
  parameter int BEAT_LG     = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_dup_source,
  output logic                   err_a_illegal,
  output logic                   err_a_burst,
  output logic                   err_d_unexpected,
  output logic                   err_d_mismatch,
  output logic [SOURCE_BITS:0]   inflight_count,
  output logic                   idle
);
  localparam int DEPTH = 1 << SOURCE_BITS;
  localparam int CW    = MAX_SIZE - BEAT_LG + 1;

  tl_entry_t tbl     [DEPTH];
  tl_entry_t tbl_nxt [DEPTH];
  a_state_e  a_state;
  d_state_e  d_state;

  logic [2:0]             a_op_q;
  logic [SIZE_BITS-1:0]   a_size_q;
  logic [SOURCE_BITS-1:0] a_src_q, d_src_q;
  logic                   d_exp_q;

  logic a_fire, d_fire, a_first, d_first, a_legal, a_multi, d_multi, d_last;
  logic alloc, free, a_busy_nxt, d_busy_nxt;
  int unsigned a_beats, d_beats;
  tl_entry_t   d_ent;
  logic [SOURCE_BITS-1:0] free_src;
  logic [SOURCE_BITS:0]   cnt_nxt;
  logic [2:0]             a_expect;

  // Index 0 tracks the A channel, index 1 the D channel.
  logic [1:0]         cnt_load, cnt_dec, cnt_last;
  logic [1:0][CW-1:0] cnt_val;

  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;
  assign a_first = a_fire && (a_state == A_IDLE);
  assign d_first = d_fire && (d_state == D_IDLE);

  assign a_beats = beats(int'(a_size), BEAT_LG);
  assign d_beats = beats(int'(d_size), BEAT_LG);
  assign a_legal = (a_opcode inside {OP_PUT_FULL, OP_PUT_PARTIAL, OP_GET}) && (int'(a_size) <= MAX_SIZE);
  assign a_multi = a_legal && (a_opcode != OP_GET) && (a_beats > 1);
  assign d_multi = (d_opcode == OP_ACCESS_ACK_DATA) && (int'(d_size) <= MAX_SIZE) && (d_beats > 1);
  assign a_expect = (a_opcode == OP_GET) ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;

  assign cnt_load = {d_first && d_multi, a_first && a_multi};
  assign cnt_dec  = {d_fire && (d_state == D_BURST), a_fire && (a_state == A_BURST)};
  assign cnt_val  = {CW'(d_beats - 1), CW'(a_beats - 1)};

  tl_beat_counter #(.W(CW)) u_cnt [1:0] (
    .clk      (clock),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  assign d_ent  = tbl[d_source];
  assign d_last = d_fire && ((d_state == D_IDLE) ? !d_multi : cnt_last[1]);
  // An unexpected response still counts its beats but must never free an entry.
  assign free_src = (d_state == D_IDLE) ? d_source : d_src_q;
  assign free     = d_last && ((d_state == D_IDLE) ? d_ent.valid : d_exp_q);
  assign alloc    = a_first && a_legal;

  assign a_busy_nxt = (a_state == A_IDLE) ? cnt_load[0] : !(cnt_dec[0] && cnt_last[0]);
  assign d_busy_nxt = (d_state == D_IDLE) ? cnt_load[1] : !(cnt_dec[1] && cnt_last[1]);

  // Free lands before allocation so a same-cycle reuse of a retiring source is clean.
  always_comb begin
    tbl_nxt = tbl;
    if (free)  tbl_nxt[free_src] = '0;
    if (alloc) tbl_nxt[a_source] = '{valid: 1'b1, expect_opcode: a_expect,
                                     size: TL_SIZE_BITS'(a_size)};
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt += (SOURCE_BITS+1)'(tbl_nxt[i].valid);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      a_state          <= A_IDLE;
      d_state          <= D_IDLE;
      a_op_q           <= '0;
      a_size_q         <= '0;
      a_src_q          <= '0;
      d_src_q          <= '0;
      d_exp_q          <= 1'b0;
      err_dup_source   <= 1'b0;
      err_a_illegal    <= 1'b0;
      err_a_burst      <= 1'b0;
      err_d_unexpected <= 1'b0;
      err_d_mismatch   <= 1'b0;
      inflight_count   <= '0;
      idle             <= 1'b1;
    end else begin
      tbl <= tbl_nxt;
      case (a_state)
        A_IDLE:  if (cnt_load[0]) begin
                   a_state  <= A_BURST;
                   a_op_q   <= a_opcode;
                   a_size_q <= a_size;
                   a_src_q  <= a_source;
                 end
        A_BURST: if (cnt_dec[0] && cnt_last[0]) a_state <= A_IDLE;
        default: a_state <= A_IDLE;
      endcase
      case (d_state)
        D_IDLE:  if (cnt_load[1]) begin
                   d_state <= D_BURST;
                   d_src_q <= d_source;
                   d_exp_q <= d_ent.valid;
                 end
        D_BURST: if (cnt_dec[1] && cnt_last[1]) d_state <= D_IDLE;
        default: d_state <= D_IDLE;
      endcase
      err_dup_source   <= alloc && tbl[a_source].valid && !(free && free_src == a_source);
      err_a_illegal    <= a_first && !a_legal;
      err_a_burst      <= cnt_dec[0] && (a_opcode != a_op_q || a_size != a_size_q || a_source != a_src_q);
      err_d_unexpected <= d_first && !d_ent.valid;
      err_d_mismatch   <= d_first && d_ent.valid &&
                          (d_opcode != d_ent.expect_opcode || TL_SIZE_BITS'(d_size) != d_ent.size);
      inflight_count   <= cnt_nxt;
      idle             <= (cnt_nxt == '0) && !a_busy_nxt && !d_busy_nxt;
    end
  end
endmodule
